// File: rtl/id_ex_alu_issue_if.sv
// ID/EX issue bus between the decode side, the EX register stage and the ALU.
// master: drives the ID-side instruction fields, stall/flush and the ALU
//         branch result; observes the EX outputs, redirect and counters.
// slave : the ID/EX stage itself (id_ex_alu_issue).
interface id_ex_alu_issue_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [2:0]       id_funct3;
  logic [6:0]       id_funct7;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_pc;
  logic             stall;
  logic             flush;
  logic             alu_branch_mux;
  logic             id_ready;
  logic             ex_valid;
  logic [3:0]       Alu_opr;
  logic [XLEN-1:0]  IP_data1;
  logic [XLEN-1:0]  IP_data2;
  logic [XLEN-1:0]  ex_store_data;
  logic [4:0]       ex_rd;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_is_branch;
  logic             ex_illegal;
  logic             redirect;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7, id_rs1_data, id_rs2_data,
           id_imm, id_rd, id_pc, stall, flush, alu_branch_mux,
    input  id_ready, ex_valid, Alu_opr, IP_data1, IP_data2, ex_store_data,
           ex_rd, ex_pc, ex_is_branch, ex_illegal, redirect, issue_count,
           redirect_count
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7, id_rs1_data, id_rs2_data,
           id_imm, id_rd, id_pc, stall, flush, alu_branch_mux,
    output id_ready, ex_valid, Alu_opr, IP_data1, IP_data2, ex_store_data,
           ex_rd, ex_pc, ex_is_branch, ex_illegal, redirect, issue_count,
           redirect_count
  );
endinterface

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline stage feeding the 64-bit ALU.
// Decodes opcode/funct3/funct7 into the 4-bit ALU operation, selects operand 2
// (rs2 or immediate) and registers the instruction for EX. A taken branch in
// EX (alu_branch_mux low) raises redirect and squashes the ID instruction.
// Ports: clk, reset (sync, active-high), bus (id_ex_alu_issue_if.slave):
//   ID inputs id_*, stall, flush, alu_branch_mux; outputs id_ready, ex_*,
//   Alu_opr, IP_data1/2, redirect, issue_count, redirect_count.
module id_ex_alu_issue #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  id_ex_alu_issue_if.slave   bus
);
  localparam logic [3:0] OP_ILL = 4'b1111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---- p0: combinational decode on the ID side ----
  logic [3:0] dec_op_p0;
  logic       dec_imm_p0;
  logic       dec_br_p0;
  logic       dec_ill_p0;

  always_comb begin
    dec_op_p0  = OP_ILL;
    dec_imm_p0 = 1'b0;
    dec_br_p0  = 1'b0;
    case (bus.id_opcode)
      7'b0110011, 7'b0010011: begin
        dec_imm_p0 = (bus.id_opcode == 7'b0010011);
        case (bus.id_funct3)
          // funct7[5] selects sub only for the register form; addi ignores it
          3'b000:  dec_op_p0 = (!dec_imm_p0 && bus.id_funct7[5]) ? 4'b0001 : 4'b0000;
          3'b001:  dec_op_p0 = 4'b0010;
          3'b100:  dec_op_p0 = 4'b0011;
          // arithmetic shifts are not supported by the ALU
          3'b101:  dec_op_p0 = (bus.id_funct7 == 7'd0) ? 4'b0100 : OP_ILL;
          3'b110:  dec_op_p0 = 4'b0101;
          3'b111:  dec_op_p0 = 4'b0110;
          default: dec_op_p0 = OP_ILL;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        dec_op_p0  = 4'b0000;
        dec_imm_p0 = 1'b1;
      end
      7'b1100011: begin
        case (bus.id_funct3)
          3'b000:  dec_op_p0 = 4'b0111;
          3'b001:  dec_op_p0 = 4'b1000;
          3'b100:  dec_op_p0 = 4'b1001;
          3'b101:  dec_op_p0 = 4'b1010;
          default: dec_op_p0 = OP_ILL;
        endcase
        dec_br_p0 = (dec_op_p0 != OP_ILL);
      end
      default: ;
    endcase
    dec_ill_p0 = (dec_op_p0 == OP_ILL);
  end

  // ---- p1: EX register stage ----
  logic             vld_p1;
  logic [3:0]       op_p1;
  logic [XLEN-1:0]  d1_p1;
  logic [XLEN-1:0]  d2_p1;
  logic [XLEN-1:0]  sd_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [4:0]       rd_p1;
  logic             br_p1;
  logic             ill_p1;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] redirect_cnt;
  logic             redirect;
  logic             kill;

  assign redirect = vld_p1 & br_p1 & ~bus.alu_branch_mux;
  // a taken branch squashes the wrong-path ID instruction even while stalled
  assign kill     = bus.flush | redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      op_p1  <= OP_ILL;
      br_p1  <= 1'b0;
      ill_p1 <= 1'b0;
      d1_p1  <= '0;
      d2_p1  <= '0;
      sd_p1  <= '0;
      pc_p1  <= '0;
      rd_p1  <= '0;
    end else if (kill) begin
      vld_p1 <= 1'b0;
      op_p1  <= OP_ILL;
      br_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (!bus.stall) begin
      vld_p1 <= bus.id_valid;
      op_p1  <= bus.id_valid ? dec_op_p0  : OP_ILL;
      br_p1  <= bus.id_valid & dec_br_p0;
      ill_p1 <= bus.id_valid & dec_ill_p0;
      d1_p1  <= bus.id_rs1_data;
      d2_p1  <= dec_imm_p0 ? bus.id_imm : bus.id_rs2_data;
      sd_p1  <= bus.id_rs2_data;
      pc_p1  <= bus.id_pc;
      rd_p1  <= bus.id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!kill && !bus.stall && bus.id_valid) issue_cnt <= sat_inc(issue_cnt);
      if (redirect) redirect_cnt <= sat_inc(redirect_cnt);
    end
  end

  assign bus.id_ready       = ~bus.stall;
  assign bus.ex_valid       = vld_p1;
  assign bus.Alu_opr        = op_p1;
  assign bus.IP_data1       = d1_p1;
  assign bus.IP_data2       = d2_p1;
  assign bus.ex_store_data  = sd_p1;
  assign bus.ex_rd          = rd_p1;
  assign bus.ex_pc          = pc_p1;
  assign bus.ex_is_branch   = br_p1;
  assign bus.ex_illegal     = ill_p1;
  assign bus.redirect       = redirect;
  assign bus.issue_count    = issue_cnt;
  assign bus.redirect_count = redirect_cnt;
endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage that drives the 64-bit ALU.
- Decodes opcode/funct3/funct7 into the ALU's 4-bit operation code, selects operand 2 (rs2 or immediate), and registers everything for the EX stage.
- Consumes the ALU's active-low branch result to produce a redirect and squash the wrong-path instruction in ID.
- Handles stall, flush and bubble insertion, and keeps issue/redirect counters.

Parameters:
- XLEN, 64, datapath width
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  7  instruction[6:0]
- id_funct3  in  3  instruction[14:12]
- id_funct7  in  7  instruction[31:25]
- id_rs1_data  in  XLEN  register operand 1
- id_rs2_data  in  XLEN  register operand 2
- id_imm  in  XLEN  sign-extended immediate
- id_rd  in  5  destination register
- id_pc  in  XLEN  instruction PC
- stall  in  1  hold EX register contents
- flush  in  1  external squash
- alu_branch_mux  in  1  ALU branch result, 0 = condition true (taken)
- id_ready  out  1  = ~stall
- ex_valid  out  1  EX holds a valid instruction
- Alu_opr  out  4  ALU operation code
- IP_data1  out  XLEN  ALU operand 1
- IP_data2  out  XLEN  ALU operand 2
- ex_store_data  out  XLEN  registered rs2 (store data)
- ex_rd  out  5  destination register
- ex_pc  out  XLEN  PC of EX instruction
- ex_is_branch  out  1  EX instruction is a conditional branch
- ex_illegal  out  1  EX instruction was not decodable
- redirect  out  1  branch taken in EX (combinational)
- issue_count  out  CNT_W  valid instructions loaded into EX
- redirect_count  out  CNT_W  redirects asserted

Behaviour:
Decode (combinational, ID side):
- R-type 0110011, operand2 = rs2:
  - f3=000 with f7[5]=0 → 0000 (add); with f7[5]=1 → 0001 (sub)
  - 001 → 0010 (sll); 100 → 0011 (xor); 101 with f7=0 → 0100 (srl); 110 → 0101 (or); 111 → 0110 (and)
- I-type 0010011, operand2 = imm: same funct3 mapping; 000 is always 0000.
- Load 0000011 and store 0100011: 0000, operand2 = imm.
- Branch 1100011, operand2 = rs2, is_branch = 1:
  - 000 → 0111 (beq); 001 → 1000 (bne); 100 → 1001 (blt); 101 → 1010 (bge)
- Anything else is illegal: op 1111, illegal = 1, is_branch = 0. This includes sra/srai (f3=101, f7[5]=1), bltu/bgeu, and unknown opcodes.
- IP_data1 is always rs1.

Redirect:
- redirect = ex_valid & ex_is_branch & ~alu_branch_mux (same cycle as EX).

Register update at posedge clk, priority reset > kill > stall > load, where kill = flush | redirect:
- reset: ex_valid=0, Alu_opr=1111, IP_data1/IP_data2/ex_store_data/ex_pc=0, ex_rd=0, ex_is_branch=0, ex_illegal=0, both counters=0.
- kill: ex_valid=0, Alu_opr=1111, ex_is_branch=0, ex_illegal=0; data registers hold their values.
  - Kill overrides stall: a stalled branch that redirects still clears EX.
- stall (no kill): all EX registers hold.
- load: ex_valid=id_valid and all fields take decoded values.
  - If id_valid=0, Alu_opr=1111, ex_is_branch=0, ex_illegal=0.
- Illegal instructions do load with ex_valid=1 and ex_illegal=1, so a later stage can trap.

Latency and handshake:
- ID→EX latency is 1 cycle.
- id_ready=0 during stall; ID must hold its inputs.

Counters:
- issue_count increments on a load with id_valid=1.
- redirect_count increments on each cycle where redirect=1.
- Both saturate at all-ones and never wrap.
- Reset mid-operation clears both counters.

Test Plan:
- Reset asserted 2 cycles → ex_valid=0, Alu_opr=1111, counters 0, redirect=0.
- R-type add then sub (f7=0100000), rs1=10, rs2=3 → next cycle Alu_opr=0000, IP_data2=3; following cycle Alu_opr=0001, issue_count=2.
- addi with rs1=5, imm=-1 → Alu_opr=0000, IP_data2=0xFFFF_FFFF_FFFF_FFFF, ex_store_data=rs2.
- beq in EX with alu_branch_mux=0 and a valid add in ID → redirect=1 that cycle; next cycle ex_valid=0, Alu_opr=1111, redirect_count=1, issue_count not incremented for the add. Repeat with alu_branch_mux=1 → no redirect and the add loads.
- Stall held 3 cycles with xori in EX and changing ID inputs → EX outputs unchanged, id_ready=0. Assert flush during the stall → bubble on the next edge.
- opcode 0110011 with f3=101, f7=0100000 (sra) → ex_valid=1, ex_illegal=1, Alu_opr=1111. Preload issue_count to all-ones via force, then issue → count stays all-ones.
